// File: rtl/cam_fb_if.sv
// Pixel-in / canvas-read bundle between the camera capture stage, the frame
// buffer and its readers. pix_valid qualifies pix_data; there is no ready.
interface cam_fb_if;
    logic        frame_start;
    logic        pix_valid;
    logic [8:0]  pix_data;
    logic [31:0] addr;
    logic [8:0]  q;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        overrun;

    modport master (
        output frame_start, pix_valid, pix_data, addr,
        input  q, frame_done, frame_cnt, overrun
    );

    modport slave (
        input  frame_start, pix_valid, pix_data, addr,
        output q, frame_done, frame_cnt, overrun
    );
endinterface

// File: rtl/cam_frame_buf.sv
// Decimating RGB333 frame store with a registered {y, x} read port.
// Optional build macro CAM_FB_MIRROR_EN mirrors the canvas horizontally.
module cam_frame_buf #(
    parameter int SRC_W = 640,
    parameter int SRC_H = 480,
    parameter int DEC   = 4,
    parameter int DST_W = SRC_W / DEC,
    parameter int DST_H = SRC_H / DEC
) (
    input  logic         clk,
    input  logic         rst,
    cam_fb_if.slave      bus,
    output logic [1:0]   o_dbg_state   // 0 idle, 1 capture, 2 done, 3 drain
);
    localparam int LOG_DEC = $clog2(DEC);
    localparam int SX_W    = $clog2(SRC_W);
    localparam int SY_W    = $clog2(SRC_H);
    localparam int AW      = $clog2(DST_W * DST_H);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SX_W-1:0]   r_sx;
    logic [SY_W-1:0]   r_sy;
    logic [SX_W-1:0]   w_px;
    logic [SY_W-1:0]   w_py;
    logic              w_accept;
    logic              w_last;
    logic              w_keep;
    logic              w_stray;
    logic [SX_W-LOG_DEC-1:0] w_dx;
    logic [SY_W-LOG_DEC-1:0] w_dy;
    logic [AW-1:0]     w_col;
    logic [AW-1:0]     w_waddr;
    logic [14:0]       w_ry;
    logic [14:0]       w_rx;
    logic              w_rd_in;
    logic [AW-1:0]     w_raddr;
    logic              w_unused_addr;

    logic [8:0]        r_mem [DST_W*DST_H];
    logic [8:0]        r_q;
    logic [7:0]        r_frame_cnt;
    logic              r_overrun;

    // A frame_start pixel is always position (0,0) of the new frame.
    always_comb begin
        w_px     = bus.frame_start ? '0 : r_sx;
        w_py     = bus.frame_start ? '0 : r_sy;
        w_accept = bus.pix_valid && (bus.frame_start || r_state == S_CAPTURE);
        w_last   = w_accept && (w_px == SX_W'(SRC_W - 1)) && (w_py == SY_W'(SRC_H - 1));
        w_keep   = w_accept && (w_px[LOG_DEC-1:0] == '0) && (w_py[LOG_DEC-1:0] == '0);
        w_stray  = bus.pix_valid && !bus.frame_start &&
                   (r_state == S_DONE || r_state == S_DRAIN);
        w_next   = r_state;
        case (r_state)
            S_IDLE:    if (bus.frame_start) w_next = S_CAPTURE;
            S_CAPTURE: if (w_last) w_next = S_DONE;
            S_DONE:    w_next = bus.frame_start ? S_CAPTURE : S_DRAIN;
            S_DRAIN:   if (bus.frame_start) w_next = S_CAPTURE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_dx = w_px[SX_W-1:LOG_DEC];
        w_dy = w_py[SY_W-1:LOG_DEC];
`ifdef CAM_FB_MIRROR_EN
        w_col = AW'(DST_W - 1) - AW'(w_dx);
`else
        w_col = AW'(w_dx);
`endif
        w_waddr = AW'(w_dy) * AW'(DST_W) + w_col;
    end

    always_comb begin
        w_ry          = bus.addr[31:17];
        w_rx          = bus.addr[15:1];
        w_rd_in       = (w_ry < 15'(DST_H)) && (w_rx < 15'(DST_W));
        w_raddr       = AW'(w_ry) * AW'(DST_W) + AW'(w_rx);
        w_unused_addr = bus.addr[16] ^ bus.addr[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sx        <= '0;
            r_sy        <= '0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                if (w_px == SX_W'(SRC_W - 1)) begin
                    r_sx <= '0;
                    r_sy <= (w_py == SY_W'(SRC_H - 1)) ? '0 : w_py + 1'b1;
                end else begin
                    r_sx <= w_px + 1'b1;
                    r_sy <= w_py;
                end
            end else if (bus.frame_start) begin
                r_sx <= '0;
                r_sy <= '0;
            end
            if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 8'd1;
            if (w_stray) r_overrun <= 1'b1;
        end
    end

    // Canvas survives reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (!rst && w_keep) r_mem[w_waddr] <= bus.pix_data;
    end

    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else     r_q <= w_rd_in ? r_mem[w_raddr] : '0;
    end

    assign bus.q          = r_q;
    assign bus.frame_done = (r_state == S_DONE);
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.overrun    = r_overrun;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_cam_frame_buf.sv
// Bench for cam_frame_buf on a reduced 64x48 raster; honours CAM_FB_MIRROR_EN.
module tb_cam_frame_buf;
    localparam int SW = 64;
    localparam int SH = 48;
    localparam int D  = 4;
    localparam int DW = SW / D;
    localparam int DH = SH / D;
`ifdef CAM_FB_MIRROR_EN
    localparam bit MIRROR = 1'b1;
`else
    localparam bit MIRROR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    cam_fb_if bus();

    cam_frame_buf #(.SRC_W(SW), .SRC_H(SH), .DEC(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    typedef struct {
        string      name;
        int         x;
        int         y;
        logic [8:0] exp;
    } rd_vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_done   = 0;
    logic [8:0] model [DW*DH];
    logic [8:0] exp_q [$];
    rd_vec_t    tbl [9];

    always @(negedge clk) if (bus.frame_done === 1'b1) n_done++;

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish within its time bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit fs, input bit pv, input logic [8:0] d);
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        bus.pix_data    = d;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 9'h0);
        drive(0, 0, 9'h0);
        rst = 1'b0;
    endtask

    // Canvas slot for a kept source pixel, straight from the keep rule.
    function automatic int widx(input int sx, input int sy);
        int dx;
        dx = sx / D;
        if (MIRROR) dx = DW - 1 - dx;
        return (sy / D) * DW + dx;
    endfunction

    function automatic logic [31:0] mk_addr(input int x, input int y);
        logic [31:0] a;
        a = {y[14:0], 1'($urandom_range(0, 1)), x[14:0], 1'($urandom_range(0, 1))};
        return a;
    endfunction

    function automatic logic [8:0] exp_rd(input int x, input int y);
        if (x >= 0 && x < DW && y >= 0 && y < DH) return model[y * DW + x];
        return 9'h0;
    endfunction

    function automatic logic [8:0] pat(input int x, input int y);
        int sx;
        sx = MIRROR ? (DW - 1 - x) : x;
        return 9'((4 * sx + 4 * y) & 'h1FF);
    endfunction

    task automatic send_frame(input int npix, input bit rand_data, input bit gaps);
        int sx = 0;
        int sy = 0;
        logic [8:0] d;
        for (int i = 0; i < npix; i++) begin
            if (gaps && i != 0 && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) drive(0, 0, 9'($urandom));
            d = rand_data ? 9'($urandom) : 9'((sx + sy) & 'h1FF);
            if (sx % D == 0 && sy % D == 0) model[widx(sx, sy)] = d;
            drive(i == 0, 1, d);
            sx++;
            if (sx == SW) begin
                sx = 0;
                sy++;
            end
        end
    endtask

    task automatic rand_reads(input int n);
        int x;
        int y;
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, DW + 2);
            y = $urandom_range(0, DH + 2);
            if ($urandom_range(0, 7) == 0) y = $urandom_range(DH, 32767);
            exp_q.push_back(exp_rd(x, y));
            bus.addr = mk_addr(x, y);
            @(negedge clk);
            check("rand_read", bus.q, exp_q.pop_front());
        end
    endtask

    initial begin
        int snap;
        int tx;
        logic [8:0] old;
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = '0;
        bus.addr        = '0;
        tx = MIRROR ? DW - 1 : 0;

        do_reset();
        check("rst_q", bus.q, 0);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_state", dbg_state, 0);

        // Pixels without frame_start are ignored in idle.
        repeat (6) drive(0, 1, 9'($urandom));
        check("idle_state", dbg_state, 0);
        check("idle_overrun", bus.overrun, 0);
        check("idle_done", bus.frame_done, 0);

        // Full frame with the (sx+sy) pattern, no gaps.
        snap = n_done;
        send_frame(SW * SH, 0, 0);
        check("a_done_pulse", bus.frame_done, 1);
        drive(0, 0, 9'h0);
        check("a_done_low", bus.frame_done, 0);
        check("a_frame_cnt", bus.frame_cnt, 1);
        drive(0, 0, 9'h0);
        check("a_done_count", n_done - snap, 1);
        check("a_state_drain", dbg_state, 3);

        tbl[0] = '{"rd_0_0",       0,      0,      pat(0, 0)};
        tbl[1] = '{"rd_last",      DW - 1, DH - 1, pat(DW - 1, DH - 1)};
        tbl[2] = '{"rd_3_2",       3,      2,      pat(3, 2)};
        tbl[3] = '{"rd_xmax_y0",   DW - 1, 0,      pat(DW - 1, 0)};
        tbl[4] = '{"rd_x0_ymax",   0,      DH - 1, pat(0, DH - 1)};
        tbl[5] = '{"rd_x_oob",     DW,     0,      9'h0};
        tbl[6] = '{"rd_y_oob",     0,      DH,     9'h0};
        tbl[7] = '{"rd_y_huge",    2,      32767,  9'h0};
        tbl[8] = '{"rd_xy_oob",    DW,     DH,     9'h0};
        for (int i = 0; i < 9; i++) begin
            bus.addr = mk_addr(tbl[i].x, tbl[i].y);
            @(negedge clk);
            check(tbl[i].name, bus.q, tbl[i].exp);
        end

        // Abandoned short frame followed by a full random frame with gaps.
        do_reset();
        check("b_rst_cnt", bus.frame_cnt, 0);
        snap = n_done;
        send_frame(1000, 1, 1);
        send_frame(SW * SH, 1, 1);
        check("b_done_pulse", bus.frame_done, 1);
        drive(0, 0, 9'h0);
        drive(0, 0, 9'h0);
        check("b_frame_cnt", bus.frame_cnt, 1);
        check("b_done_count", n_done - snap, 1);
        rand_reads(40);

        // Stray pixels after the frame: sticky overrun, no writes.
        check("c_overrun_pre", bus.overrun, 0);
        repeat (5) drive(0, 1, 9'($urandom));
        check("c_overrun", bus.overrun, 1);
        check("c_frame_cnt", bus.frame_cnt, 1);
        check("c_state_drain", dbg_state, 3);
        rand_reads(20);

        // frame_start with a pixel writes (0,0); same-cycle read sees old data.
        bus.addr = mk_addr(tx, 0);
        old = model[widx(0, 0)];
        model[widx(0, 0)] = 9'h1AB;
        drive(1, 1, 9'h1AB);
        check("c_rbw_old", bus.q, old);
        drive(0, 0, 9'h0);
        check("c_fs_pixel_new", bus.q, 9'h1AB);
        check("c_state_capture", dbg_state, 1);
        check("c_overrun_sticky", bus.overrun, 1);

        do_reset();
        check("d_overrun_clr", bus.overrun, 0);
        check("d_state_idle", dbg_state, 0);
        check("d_q_clr", bus.q, 0);
        check("d_frame_cnt", bus.frame_cnt, 0);
        repeat (8) drive(0, 1, 9'($urandom));
        bus.addr = mk_addr(tx, 0);
        @(negedge clk);
        check("d_no_write_idle", bus.q, 9'h1AB);
        check("d_overrun_idle", bus.overrun, 0);
        rand_reads(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
